bcd_serial_add_ctrl: RTL and testbench

- Digit-serial sequencer that adds two DIGITS-wide packed BCD operands.
- Reuses one single-digit BCD add-with-carry stage, stepping once per clock from least-significant digit upward.
- Sits between operand/control logic and the result register of the decimal ALU path.
- Handles the start/busy/done handshake, carry chaining, result assembly and invalid-digit flagging.

---
 rtl/bcd_serial_add_ctrl_if.sv | 33 +++
 rtl/bcd_serial_add_ctrl.sv | 148 ++++++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_serial_add_ctrl_if.sv
// Operand/result bundle between the decimal ALU control and the serial BCD adder.
// The sub line exists only when BCD_SUB_EN is defined.
interface bcd_serial_add_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
`ifdef BCD_SUB_EN
    logic                  sub;
`endif
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   sum;
    logic                  cout;
    logic                  err;

    modport master (
`ifdef BCD_SUB_EN
        output sub,
`endif
        output start, a, b,
        input  busy, done, sum, cout, err
    );

    modport slave (
`ifdef BCD_SUB_EN
        input  sub,
`endif
        input  start, a, b,
        output busy, done, sum, cout, err
    );
endinterface

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder sequencer: one add-with-carry digit stage, LSD first (BCD_SUB_EN adds ten's-complement subtract).
// Latency: start accepted at edge 0, busy for DIGITS cycles, done pulses in cycle DIGITS+1.
// No backpressure: start is only sampled in IDLE; starts during ADD/DONE are dropped, not queued.
module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    bcd_serial_add_ctrl_if.slave  io
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic            carry;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic            busy_q;
    logic            done_q;
    logic            cout_q;
    logic            err_q;
    logic            sub_q;

    logic [3:0]      a_d;
    logic [3:0]      b_d;
    logic [3:0]      b_eff;
    logic [4:0]      s;
    logic [3:0]      dig;
    logic            c_nxt;
    logic            bad;

`ifndef BCD_SUB_EN
    assign sub_q = 1'b0;
`endif

    // Select the current digit pair from the latched operands.
    always_comb begin
        a_d = 4'd0;
        b_d = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                a_d = a_q[4*i +: 4];
                b_d = b_q[4*i +: 4];
            end
        end
    end

    // Single-digit decimal add stage; in subtract mode B is nines-complemented
    // and an invalid B digit is forced to 0 (err still reports it).
    always_comb begin
        b_eff = b_d;
        if (sub_q) begin
            b_eff = (b_d > 4'd9) ? 4'd0 : (4'd9 - b_d);
        end
        s     = {1'b0, a_d} + {1'b0, b_eff} + {4'd0, carry};
        dig   = s[3:0];
        c_nxt = 1'b0;
        if (s > 5'd9) begin
            dig   = s[3:0] + 4'd6;
            c_nxt = 1'b1;
        end
        bad = (a_d > 4'd9) || (b_d > 4'd9);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cout_q <= 1'b0;
            err_q  <= 1'b0;
`ifdef BCD_SUB_EN
            sub_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (io.start) begin
                        a_q    <= io.a;
                        b_q    <= io.b;
                        sum_q  <= '0;
                        cout_q <= 1'b0;
                        err_q  <= 1'b0;
                        idx    <= '0;
                        busy_q <= 1'b1;
                        state  <= ADD;
`ifdef BCD_SUB_EN
                        sub_q  <= io.sub;
                        carry  <= io.sub;
`else
                        carry  <= 1'b0;
`endif
                    end
                end
                ADD: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (idx == IW'(i)) begin
                            sum_q[4*i +: 4] <= dig;
                        end
                    end
                    if (bad) begin
                        err_q <= 1'b1;
                    end
                    carry <= c_nxt;
                    if (idx == LAST) begin
                        cout_q <= c_nxt;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign io.busy = busy_q;
    assign io.done = done_q;
    assign io.sum  = sum_q;
    assign io.cout = cout_q;
    assign io.err  = err_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Scoreboard bench for bcd_serial_add_ctrl: decimal reference model, randomized and directed operands.
module tb_bcd_serial_add_ctrl;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
        int           done_cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_pass;
    int   busy_cnt;
    exp_t expq[$];

    bcd_serial_add_ctrl_if #(.DIGITS(DIGITS)) io ();

    bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic logic [W-1:0] to_bcd(input longint v);
        logic [W-1:0] r;
        longint t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Valid operands use plain decimal arithmetic; invalid digits fall back to
    // the literal per-digit carry rule, which is what defines those results.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input int dc);
        exp_t   e;
        longint av, bv, m, r;
        bit     valid;
        int     c, ad, bd, be, s;
        av = 0; bv = 0; m = 1; valid = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            ad = int'(a[4*i +: 4]);
            bd = int'(b[4*i +: 4]);
            if (ad > 9 || bd > 9) valid = 1'b0;
            av = av * 10 + ad;
            bv = bv * 10 + bd;
            m  = m * 10;
        end
        e.err      = !valid;
        e.done_cyc = dc;
        e.sum      = '0;
        if (valid) begin
            if (!sub) begin
                r      = av + bv;
                e.cout = (r >= m);
                e.sum  = to_bcd(r % m);
            end else if (av >= bv) begin
                e.cout = 1'b1;
                e.sum  = to_bcd(av - bv);
            end else begin
                e.cout = 1'b0;
                e.sum  = to_bcd(m - (bv - av));
            end
        end else begin
            c = sub ? 1 : 0;
            for (int i = 0; i < DIGITS; i++) begin
                ad = int'(a[4*i +: 4]);
                bd = int'(b[4*i +: 4]);
                be = sub ? ((bd > 9) ? 0 : 9 - bd) : bd;
                s  = ad + be + c;
                if (s > 9) begin
                    e.sum[4*i +: 4] = 4'((s + 6) % 16);
                    c = 1;
                end else begin
                    e.sum[4*i +: 4] = 4'(s);
                    c = 0;
                end
            end
            e.cout = (c == 1);
        end
        return e;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] v;
        for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 5) == 0) v[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(0, 15));
        return v;
    endfunction

    task automatic set_sub(input logic s);
`ifdef BCD_SUB_EN
        io.sub = s;
`endif
    endtask

    function automatic logic eff_sub(input logic s);
`ifdef BCD_SUB_EN
        return s;
`else
        return 1'b0;
`endif
    endfunction

    // Called #1 after a rising edge; returns at the same phase in an IDLE cycle.
    task automatic wait_idle();
        int n;
        n = 0;
        while ((io.busy || io.done) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("idle_timeout", n, 0);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        wait_idle();
        io.start = 1'b1;
        io.a     = a;
        io.b     = b;
        set_sub(s);
        expq.push_back(model(a, b, eff_sub(s), cyc + 1 + DIGITS));
        @(posedge clk); #1;
        io.start = 1'b0;
        io.a     = W'($urandom);
        io.b     = W'($urandom);
        set_sub(1'($urandom));
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            busy_cnt = 0;
        end else begin
            if (io.busy) busy_cnt++;
            if (io.done) begin
                if (expq.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_done: done pulse at cycle %0d, expected none", cyc);
                end else begin
                    e = expq.pop_front();
                    chk("sum", longint'(io.sum), longint'(e.sum));
                    chk("cout", longint'(io.cout), longint'(e.cout));
                    chk("err", longint'(io.err), longint'(e.err));
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("busy_cycles", busy_cnt, DIGITS);
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        int a0, hold_base, n;
        n_checks = 0; n_pass = 0; cyc = 0; busy_cnt = 0;
        reset = 1'b1;
        io.start = 1'b0;
        io.a = '0;
        io.b = '0;
        set_sub(1'b0);
        #1;
        chk("rst_busy", longint'(io.busy), 0);
        chk("rst_done", longint'(io.done), 0);
        chk("rst_sum", longint'(io.sum), 0);
        chk("rst_cout", longint'(io.cout), 0);
        chk("rst_err", longint'(io.err), 0);
        #22;
        reset = 1'b0;
        @(posedge clk); #1;

        run_op(16'h1234, 16'h4321, 1'b0);
        run_op(16'h0999, 16'h0001, 1'b0);
        run_op(16'h9999, 16'h0001, 1'b0);

        // start held through the op; operands changed after acceptance
        wait_idle();
        io.start = 1'b1;
        io.a = 16'h1111;
        io.b = 16'h2222;
        expq.push_back(model(16'h1111, 16'h2222, 1'b0, cyc + 1 + DIGITS));
        @(posedge clk); #1;
        hold_base = cyc;
        io.a = 16'h4444;
        io.b = 16'h0005;
        expq.push_back(model(16'h4444, 16'h0005, 1'b0, hold_base + 2*DIGITS + 2));
        repeat (DIGITS + 2) @(posedge clk);
        #1;
        io.start = 1'b0;
        io.a = 16'h7777;
        io.b = 16'h7777;

        run_op(16'h00A0, 16'h0001, 1'b0);
        run_op(16'h0002, 16'h0003, 1'b0);
`ifdef BCD_SUB_EN
        run_op(16'h0500, 16'h0123, 1'b1);
        run_op(16'h0100, 16'h0200, 1'b1);
        run_op(16'h0042, 16'h0042, 1'b1);
        run_op(16'h1234, 16'h4321, 1'b0);
`endif

        // asynchronous reset during the second ADD cycle abandons the op
        wait_idle();
        io.start = 1'b1;
        io.a = 16'h8765;
        io.b = 16'h1234;
        @(posedge clk); #1;
        io.start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("midrst_busy", longint'(io.busy), 0);
        chk("midrst_done", longint'(io.done), 0);
        chk("midrst_sum", longint'(io.sum), 0);
        chk("midrst_cout", longint'(io.cout), 0);
        chk("midrst_err", longint'(io.err), 0);
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #1;
        run_op(16'h0005, 16'h0005, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op(rand_bcd(), rand_bcd(), 1'($urandom));
            a0 = $urandom_range(0, 3);
            repeat (a0) @(posedge clk);
            #1;
        end

        n = 0;
        while (expq.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        chk("pending_results", expq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
